run_sequencer: RTL and testbench

//  Start/ack run controller for the 9-bit core; next-generation replacement for the ad-hoc start/ack/overflow logic.

---
 rtl/run_seq_pkg.sv | 30 +++
 rtl/sat_counter.sv | 25 ++
 rtl/run_sequencer.sv | 119 +++++++++++
 tb/tb_run_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer: state encoding, program entry table, default sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package run_seq_pkg;

  // Default sizing; the top exposes these as overridable parameters.
  localparam int DEF_NUM_PROGS   = 3;
  localparam int DEF_PC_W        = 10;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_CYCLE_LIMIT = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LOAD,
    RUN,
    DONE,
    TIMEOUT
  } run_state_t;

  // Program entry addresses, index 0 in the low slice. Entry 0 doubles as the
  // fallback for out-of-range selects, and is 0 so a freshly reset select
  // presents a zero entry address.
  localparam logic [DEF_NUM_PROGS-1:0][DEF_PC_W-1:0] ENTRY_PC = {
    10'h100,  // program 2
    10'h040,  // program 1
    10'h000   // program 0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// Latency: count reflects clr/en one cycle after they are sampled.
// Backpressure: none; en simply gates the increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority over counting; the increment stops at the top value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Start/ack run controller: IDLE -> ARMED -> LOAD -> RUN -> DONE/TIMEOUT, with entry select and watchdog.
// Latency: start fall at edge N -> pc_load in N+1, core_run from N+2; core_done at edge M -> ack from M+1.
// Backpressure: start ignored in LOAD/RUN, core_done ignored outside RUN. Optional RUN_SEQ_PERF_EN adds run_cycles.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS   = DEF_NUM_PROGS,
  parameter int PC_W        = DEF_PC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT,
  parameter int SEL_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] prog_sel,
  input  logic             core_done,
  output logic             core_run,
  output logic             pc_load,
  output logic [PC_W-1:0]  entry_pc,
  output logic             busy,
  output logic             timeout,
  output logic             ack
`ifdef RUN_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] run_cycles
`endif
);

  run_state_t       state;
  run_state_t       state_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] count;
  logic             at_limit;
  logic [DEF_PC_W-1:0] entry_sel;

  // Watchdog: cleared while loading, counts only while the core runs.
  sat_counter #(
    .W(CNT_W)
  ) u_wdog (
    .clk  (clk),
    .reset(reset),
    .clr  (state == LOAD),
    .en   (state == RUN),
    .count(count)
  );

  // Last permitted RUN cycle; a done in this same cycle still wins.
  assign at_limit = (count == CNT_W'(CYCLE_LIMIT - 1));

  // Next-state decode; start is only looked at outside LOAD/RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ARMED;
      ARMED:   if (!start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (core_done)     state_nxt = DONE;
        else if (at_limit) state_nxt = TIMEOUT;
      end
      DONE:    if (start) state_nxt = ARMED;
      TIMEOUT: if (start) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched program select and Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel_q    <= '0;
      pc_load  <= 1'b0;
      core_run <= 1'b0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      if (state == ARMED && !start) begin
        sel_q <= prog_sel;
      end
      pc_load  <= (state_nxt == LOAD);
      core_run <= (state_nxt == RUN);
      busy     <= (state_nxt == LOAD) || (state_nxt == RUN);
      ack      <= (state_nxt == DONE) || (state_nxt == TIMEOUT);
      timeout  <= (state_nxt == TIMEOUT);
    end
  end

  // Entry lookup; selects beyond the program count fall back to entry 0.
  always_comb begin
    entry_sel = ENTRY_PC[0];
    for (int i = 0; i < DEF_NUM_PROGS; i++) begin
      if (i < NUM_PROGS && int'(sel_q) == i) begin
        entry_sel = ENTRY_PC[i];
      end
    end
  end

  assign entry_pc = PC_W'(entry_sel);

`ifdef RUN_SEQ_PERF_EN
  logic [CNT_W-1:0] count_inc;

  // The exiting RUN cycle has not been counted yet, so latch one more than count.
  assign count_inc = (&count) ? count : count + CNT_W'(1);

  // Capture the run length on the edge that leaves RUN; held until the next run ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles <= '0;
    end else if (state == RUN && state_nxt != RUN) begin
      run_cycles <= count_inc;
    end
  end
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: two instances (watchdog 4096 and 16) share directed stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_run_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] prog_sel;
  logic       core_done;

  logic [1:0] core_run_v;
  logic [1:0] pc_load_v;
  logic [1:0] busy_v;
  logic [1:0] timeout_v;
  logic [1:0] ack_v;
  logic [9:0] entry_v [2];
`ifdef RUN_SEQ_PERF_EN
  logic [15:0] rc_v [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  run_sequencer #(.CYCLE_LIMIT(4096)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .core_done(core_done),
    .core_run(core_run_v[0]), .pc_load(pc_load_v[0]), .entry_pc(entry_v[0]),
    .busy(busy_v[0]), .timeout(timeout_v[0]), .ack(ack_v[0])
`ifdef RUN_SEQ_PERF_EN
    , .run_cycles(rc_v[0])
`endif
  );

  run_sequencer #(.CYCLE_LIMIT(16)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .core_done(core_done),
    .core_run(core_run_v[1]), .pc_load(pc_load_v[1]), .entry_pc(entry_v[1]),
    .busy(busy_v[1]), .timeout(timeout_v[1]), .ack(ack_v[1])
`ifdef RUN_SEQ_PERF_EN
    , .run_cycles(rc_v[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int LIM [2] = '{4096, 16};
  bit m_armed [2] = '{0, 0};
  bit m_load  [2] = '{0, 0};
  bit m_run   [2] = '{0, 0};
  bit m_ack   [2] = '{0, 0};
  bit m_to    [2] = '{0, 0};
  int m_runs  [2] = '{0, 0};   // RUN cycles already completed
  int m_sel   [2] = '{0, 0};
  int m_cyc   [2] = '{0, 0};
  bit started = 0;

  function automatic int exp_entry(input int sel);
    if (sel == 1) return 'h040;
    if (sel == 2) return 'h100;
    return 'h000;
  endfunction

  always @(posedge clk) begin
    started = 1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_armed[k] = 0; m_load[k] = 0; m_run[k] = 0; m_ack[k] = 0; m_to[k] = 0;
        m_runs[k] = 0; m_sel[k] = 0; m_cyc[k] = 0;
      end else if (m_load[k]) begin
        m_load[k] = 0; m_run[k] = 1; m_runs[k] = 0;
      end else if (m_run[k]) begin
        if (core_done) begin
          m_run[k] = 0; m_ack[k] = 1; m_cyc[k] = m_runs[k] + 1;
        end else if (m_runs[k] + 1 == LIM[k]) begin
          m_run[k] = 0; m_ack[k] = 1; m_to[k] = 1; m_cyc[k] = LIM[k];
        end else begin
          m_runs[k] = m_runs[k] + 1;
        end
      end else if (m_armed[k]) begin
        if (!start) begin
          m_armed[k] = 0; m_load[k] = 1; m_sel[k] = int'(prog_sel);
        end
      end else if (start) begin
        m_armed[k] = 1; m_ack[k] = 0; m_to[k] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("core_run[%0d]", k), 32'(core_run_v[k]), 32'(m_run[k]));
        chk($sformatf("pc_load[%0d]", k),  32'(pc_load_v[k]),  32'(m_load[k]));
        chk($sformatf("busy[%0d]", k),     32'(busy_v[k]),     32'(m_load[k] | m_run[k]));
        chk($sformatf("ack[%0d]", k),      32'(ack_v[k]),      32'(m_ack[k]));
        chk($sformatf("timeout[%0d]", k),  32'(timeout_v[k]),  32'(m_to[k]));
        chk($sformatf("entry_pc[%0d]", k), 32'(entry_v[k]),    32'(exp_entry(m_sel[k])));
`ifdef RUN_SEQ_PERF_EN
        chk($sformatf("run_cycles[%0d]", k), 32'(rc_v[k]),     32'(m_cyc[k]));
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_sel = 2'd0; core_done = 1'b0;
    step(); step();
    reset = 1'b0;

    // 1: idle with start low
    repeat (10) step();
    chk("t1_ack", 32'(ack_v), 32'd0);
    chk("t1_core_run", 32'(core_run_v), 32'd0);
    chk("t1_pc_load", 32'(pc_load_v), 32'd0);

    // 2: start high 3 cycles, release with prog_sel=1
    start = 1'b1;
    repeat (3) step();
    start = 1'b0; prog_sel = 2'd1;
    step();
    chk("t2_pc_load", 32'(pc_load_v), 32'b11);
    chk("t2_entry", 32'(entry_v[0]), 32'h040);
    chk("t2_model_entry", 32'(exp_entry(m_sel[0])), 32'h040);
    chk("t2_run_early", 32'(core_run_v), 32'd0);
    step();
    chk("t2_core_run", 32'(core_run_v), 32'b11);
    chk("t2_pc_load_drop", 32'(pc_load_v), 32'd0);

    // 3/4a: done after 25 RUN cycles; short watchdog instance times out at 16
    repeat (24) step();
    chk("t3_still_run0", 32'(core_run_v[0]), 32'd1);
    chk("t4_timeout1", 32'(timeout_v[1]), 32'd1);
    chk("t4_ack1", 32'(ack_v[1]), 32'd1);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("t3_ack0", 32'(ack_v[0]), 32'd1);
    chk("t3_timeout0", 32'(timeout_v[0]), 32'd0);
    chk("t3_model_cyc", 32'(m_cyc[0]), 32'd25);
`ifdef RUN_SEQ_PERF_EN
    chk("t3_run_cycles0", 32'(rc_v[0]), 32'd25);
    chk("t4_run_cycles1", 32'(rc_v[1]), 32'd16);
`endif

    // 5: re-arm from DONE/TIMEOUT, second run with out-of-range select
    start = 1'b1;
    step();
    chk("t5_ack_drop", 32'(ack_v), 32'd0);
    chk("t5_timeout_drop", 32'(timeout_v), 32'd0);
    step();
    start = 1'b0; prog_sel = 2'd3;
    step();
    chk("t5_entry0", 32'(entry_v[0]), 32'h000);
    chk("t5_pc_load", 32'(pc_load_v), 32'b11);
    step();
    repeat (15) step();
    chk("t4_run16_1", 32'(core_run_v[1]), 32'd1);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("t4_done_wins_ack", 32'(ack_v[1]), 32'd1);
    chk("t4_done_wins_to", 32'(timeout_v[1]), 32'd0);

    // 6: reset mid-RUN; start pulse during RUN ignored
    start = 1'b1; step();
    start = 1'b0; prog_sel = 2'd2; step();
    chk("t6_entry2", 32'(entry_v[0]), 32'h100);
    step();
    repeat (3) step();
    start = 1'b1; step();
    start = 1'b0; step();
    chk("t6_run_after_pulse", 32'(core_run_v), 32'b11);
    chk("t6_no_load", 32'(pc_load_v), 32'd0);
    reset = 1'b1; step();
    chk("t6_rst_run", 32'(core_run_v), 32'd0);
    chk("t6_rst_busy", 32'(busy_v), 32'd0);
    chk("t6_rst_entry", 32'(entry_v[0]), 32'd0);
    reset = 1'b0;
    core_done = 1'b1; step();
    core_done = 1'b0; step();
    chk("t6_idle_done_ignored", 32'(ack_v), 32'd0);

    // full-length watchdog on the default instance
    start = 1'b1; step();
    start = 1'b0; prog_sel = 2'd1; step();
    step();
    repeat (4095) step();
    chk("wd_run4096", 32'(core_run_v[0]), 32'd1);
    step();
    chk("wd_timeout", 32'(timeout_v[0]), 32'd1);
    chk("wd_ack", 32'(ack_v[0]), 32'd1);
`ifdef RUN_SEQ_PERF_EN
    chk("wd_run_cycles", 32'(rc_v[0]), 32'd4096);
`endif
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
